// File: rtl/raisin64_pkg.sv
// Shared raisin64 core constants: datapath widths, the "no register" encoding and
// default commit-stage sizing used by both commit_arb and the scheduler.
package raisin64_pkg;
    localparam int XLEN = 64;
    localparam int RN_W = 6;
    localparam logic [RN_W-1:0] RN_NONE = {RN_W{1'b0}};
    localparam int NUM_UNITS_DEF = 4;
    localparam int NUM_WPORTS_DEF = 2;

    // Number of set bits in a 32-bit vector
    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/commit_fifo.sv
// Single-channel result buffer: DEPTH entries of W bits with push/pop, full/empty
// flags and a combinational head. A full buffer refuses a push even when popping.
module commit_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = RN_W + XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_s, pop_s;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == {(AW + 1){1'b0}});
    assign head   = mem_q[rd_ptr_q];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Next-state for pointers, occupancy and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state flops; reset discards all buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/commit_arb.sv
// Commit stage: per-unit result buffers arbitrated round-robin onto NUM_WPORTS
// register-file write ports. Define COMMIT_ARB_PERF_EN to add perf counters.
module commit_arb #(
    parameter int NUM_UNITS  = raisin64_pkg::NUM_UNITS_DEF,
    parameter int NUM_WPORTS = raisin64_pkg::NUM_WPORTS_DEF,
    parameter int DEPTH      = 2,
    parameter int XLEN       = raisin64_pkg::XLEN,
    parameter int RN_W       = raisin64_pkg::RN_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_UNITS-1:0]       unit_valid,
    input  logic [NUM_UNITS*RN_W-1:0]  unit_rn,
    input  logic [NUM_UNITS*XLEN-1:0]  unit_data,
    output logic [NUM_UNITS-1:0]       unit_stall,
    output logic [NUM_WPORTS-1:0]      wr_en,
    output logic [NUM_WPORTS*RN_W-1:0] wr_rn,
    output logic [NUM_WPORTS*XLEN-1:0] wr_data
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [31:0]                perf_commits,
    output logic [31:0]                perf_stall_cycles
`endif
);
    import raisin64_pkg::*;

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [RN_W-1:0] RN_ZERO = RN_W'(RN_NONE);

    logic [NUM_UNITS-1:0]       push_s, pop_s, full_s, empty_s;
    logic [RN_W+XLEN-1:0]       head_s      [NUM_UNITS];
    logic [RN_W-1:0]            head_rn_s   [NUM_UNITS];
    logic [XLEN-1:0]            head_data_s [NUM_UNITS];

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_WPORTS-1:0]      wr_en_q, wr_en_d;
    logic [NUM_WPORTS*RN_W-1:0] wr_rn_q, wr_rn_d;
    logic [NUM_WPORTS*XLEN-1:0] wr_data_q, wr_data_d;

    // Zero-register results are accepted but never enter a buffer
    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        assign push_s[i] = unit_valid[i] & ~full_s[i]
                         & (unit_rn[i*RN_W +: RN_W] != RN_ZERO);

        commit_fifo #(
            .DEPTH (DEPTH),
            .W     (RN_W + XLEN)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[i]),
            .push_data ({unit_rn[i*RN_W +: RN_W], unit_data[i*XLEN +: XLEN]}),
            .pop       (pop_s[i]),
            .full      (full_s[i]),
            .empty     (empty_s[i]),
            .head      (head_s[i])
        );

        assign head_rn_s[i]   = head_s[i][RN_W+XLEN-1 -: RN_W];
        assign head_data_s[i] = head_s[i][XLEN-1:0];
    end

    assign unit_stall = full_s;

    // Round-robin scan from rr_ptr; a head repeating a granted rn waits a cycle
    always_comb begin
        int idx;
        int n_grant;
        logic conflict;
        wr_en_d   = {NUM_WPORTS{1'b0}};
        wr_rn_d   = {(NUM_WPORTS*RN_W){1'b0}};
        wr_data_d = {(NUM_WPORTS*XLEN){1'b0}};
        pop_s     = {NUM_UNITS{1'b0}};
        rr_ptr_d  = rr_ptr_q;
        n_grant   = 0;
        idx       = 0;
        conflict  = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx      = (int'(rr_ptr_q) + k) % NUM_UNITS;
            conflict = 1'b0;
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (wr_en_d[p] && (wr_rn_d[p*RN_W +: RN_W] == head_rn_s[idx])) begin
                    conflict = 1'b1;
                end else begin
                    conflict = conflict;
                end
            end
            if (!empty_s[idx] && !conflict && (n_grant < NUM_WPORTS)) begin
                wr_en_d[n_grant]                   = 1'b1;
                wr_rn_d[n_grant*RN_W +: RN_W]      = head_rn_s[idx];
                wr_data_d[n_grant*XLEN +: XLEN]    = head_data_s[idx];
                pop_s[idx]                         = 1'b1;
                rr_ptr_d                           = PTR_W'((idx + 1) % NUM_UNITS);
                n_grant                            = n_grant + 1;
            end else begin
                n_grant = n_grant;
            end
        end
    end

    // Write-port output registers and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= {PTR_W{1'b0}};
            wr_en_q   <= {NUM_WPORTS{1'b0}};
            wr_rn_q   <= {(NUM_WPORTS*RN_W){1'b0}};
            wr_data_q <= {(NUM_WPORTS*XLEN){1'b0}};
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_rn_q   <= wr_rn_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_rn   = wr_rn_q;
    assign wr_data = wr_data_q;

`ifdef COMMIT_ARB_PERF_EN
    logic [31:0] perf_commits_q, perf_commits_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [32:0] commits_sum_s;

    // Saturating commit and stall-cycle counters
    always_comb begin
        commits_sum_s = {1'b0, perf_commits_q} + {1'b0, popcount32(32'(wr_en_q))};
        if (commits_sum_s[32]) begin
            perf_commits_d = 32'hFFFF_FFFF;
        end else begin
            perf_commits_d = commits_sum_s[31:0];
        end
        if ((|(unit_valid & unit_stall)) && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter flops
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_commits_q <= perf_commits_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_commits      = perf_commits_q;
    assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_commit_arb.sv
// Directed bench for commit_arb with default parameters (4 units, 2 ports, depth 2).
module tb_commit_arb;
    logic         clk;
    logic         rst;
    logic [3:0]   unit_valid;
    logic [23:0]  unit_rn;
    logic [255:0] unit_data;
    logic [3:0]   unit_stall;
    logic [1:0]   wr_en;
    logic [11:0]  wr_rn;
    logic [127:0] wr_data;
`ifdef COMMIT_ARB_PERF_EN
    logic [31:0]  perf_commits;
    logic [31:0]  perf_stall_cycles;
`endif

    int vectors;
    int miscompares;

    commit_arb dut (
        .clk        (clk),
        .rst        (rst),
        .unit_valid (unit_valid),
        .unit_rn    (unit_rn),
        .unit_data  (unit_data),
        .unit_stall (unit_stall),
        .wr_en      (wr_en),
        .wr_rn      (wr_rn),
        .wr_data    (wr_data)
`ifdef COMMIT_ARB_PERF_EN
        ,
        .perf_commits      (perf_commits),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_unit(input int i, input logic [5:0] rn, input logic [63:0] data);
        unit_rn[i*6 +: 6]     = rn;
        unit_data[i*64 +: 64] = data;
    endtask

    initial begin
        logic [5:0] bp_next_rn;
        logic [5:0] bp_exp_rn;
        logic [5:0] obs_rn;
        logic       accept3;
        int         bp_accepts;
        int         bp_seen;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        unit_valid  = 4'b0000;
        unit_rn     = 24'd0;
        unit_data   = 256'd0;

        // Reset state
        step();
        step();
        chk("rst_wr_en", wr_en, 2'b00);
        chk("rst_wr_rn", wr_rn, 12'd0);
        chk("rst_wr_data", wr_data, 128'd0);
        chk("rst_stall", unit_stall, 4'b0000);
        rst = 1'b0;
        step();
        chk("idle_wr_en", wr_en, 2'b00);

        // Contention: four units at once, two ports
        unit_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_unit(i, 6'(i + 1), 64'h100 + 64'(i));
        step();
        unit_valid = 4'b0000;
        step();
        chk("cont1_en", wr_en, 2'b11);
        chk("cont1_rn", wr_rn, {6'd2, 6'd1});
        chk("cont1_data", wr_data, {64'h101, 64'h100});
        step();
        chk("cont2_en", wr_en, 2'b11);
        chk("cont2_rn", wr_rn, {6'd4, 6'd3});
        chk("cont2_data", wr_data, {64'h103, 64'h102});
        step();
        chk("cont3_en", wr_en, 2'b00);
        chk("cont3_rn", wr_rn, 12'd0);

        // rr_ptr back at 0: unit 0 wins port 0 over unit 3
        unit_valid = 4'b1001;
        set_unit(0, 6'd10, 64'h10);
        set_unit(3, 6'd9, 64'h39);
        step();
        unit_valid = 4'b0000;
        step();
        chk("rr_en", wr_en, 2'b11);
        chk("rr_rn", wr_rn, {6'd9, 6'd10});
        chk("rr_data", wr_data, {64'h39, 64'h10});

        // Single uncontended result
        unit_valid = 4'b0100;
        set_unit(2, 6'd5, 64'hDEAD_BEEF);
        step();
        unit_valid = 4'b0000;
        step();
        chk("single_en", wr_en, 2'b01);
        chk("single_rn", wr_rn, 12'd5);
        chk("single_data", wr_data, 128'hDEAD_BEEF);
        step();
        chk("single_after_en", wr_en, 2'b00);

        // Zero register held valid for three cycles
        unit_valid = 4'b0010;
        set_unit(1, 6'd0, 64'h5555);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("zero_en", wr_en, 2'b00);
            chk("zero_stall", unit_stall[1], 1'b0);
        end
        unit_valid = 4'b0000;
        step();
        chk("zero_after_en", wr_en, 2'b00);

        // Same register from units 0 and 1 (rr_ptr is 3 here)
        unit_valid = 4'b0011;
        set_unit(0, 6'd7, 64'hAAAA);
        set_unit(1, 6'd7, 64'hBBBB);
        step();
        unit_valid = 4'b0000;
        step();
        chk("same1_en", wr_en, 2'b01);
        chk("same1_rn", wr_rn, 12'd7);
        chk("same1_data", wr_data, 128'hAAAA);
        step();
        chk("same2_en", wr_en, 2'b01);
        chk("same2_rn", wr_rn, 12'd7);
        chk("same2_data", wr_data, 128'hBBBB);
        step();
        chk("same3_en", wr_en, 2'b00);

        // Reset with three buffered entries
        unit_valid = 4'b0111;
        set_unit(0, 6'd11, 64'h11);
        set_unit(1, 6'd12, 64'h12);
        set_unit(2, 6'd13, 64'h13);
        step();
        unit_valid = 4'b0000;
        rst = 1'b1;
        step();
        chk("mid_rst_en", wr_en, 2'b00);
        rst = 1'b0;
        step();
        chk("post_rst_en", wr_en, 2'b00);
        chk("post_rst_stall", unit_stall, 4'b0000);
        chk("post_rst_rn", wr_rn, 12'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_rst_stale", wr_en, 2'b00);
        end

        // Back-pressure on unit 3 while units 0 and 1 keep ports busy
        bp_next_rn = 6'd30;
        bp_exp_rn  = 6'd30;
        bp_accepts = 0;
        bp_seen    = 0;
        set_unit(0, 6'd20, 64'h20);
        set_unit(1, 6'd21, 64'h21);
        for (int c = 0; c < 24; c++) begin
            if (c < 10) begin
                unit_valid = 4'b1011;
                set_unit(3, bp_next_rn, 64'h3000 + 64'(bp_next_rn));
            end else begin
                unit_valid = 4'b0000;
            end
            accept3 = unit_valid[3] && !unit_stall[3];
            step();
            if (accept3) begin
                bp_accepts++;
                bp_next_rn = bp_next_rn + 6'd1;
            end
            if (c == 0) chk("bp_stall3_after1", unit_stall[3], 1'b0);
            if (c == 1) chk("bp_stall3_after2", unit_stall[3], 1'b1);
            for (int p = 0; p < 2; p++) begin
                obs_rn = wr_rn[p*6 +: 6];
                if (wr_en[p] && (obs_rn >= 6'd30)) begin
                    chk("bp_order_rn", obs_rn, bp_exp_rn);
                    chk("bp_order_data", wr_data[p*64 +: 64], 64'h3000 + 64'(bp_exp_rn));
                    bp_exp_rn = bp_exp_rn + 6'd1;
                    bp_seen++;
                end
            end
        end
        chk("bp_commit_count", 128'(bp_seen), 128'(bp_accepts));
        chk("bp_drained_en", wr_en, 2'b00);
        chk("bp_drained_stall", unit_stall, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
